// File: rtl/gen_seq_genius.sv
// Genius colour-sequence generator: LFSR-filled sequence memory, timed one-hot playback
// and a registered random-access lookup for the player-input checker.
module gen_seq_genius #(
  parameter int unsigned N_CORES     = 4,
  parameter int unsigned SEQ_DEPTH   = 16,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int unsigned SHOW_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 2,
  localparam int unsigned ADDR_W     = $clog2(SEQ_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 novo_jogo,
  input  logic                 tocar,
  input  logic [ADDR_W:0]      nivel,
  input  logic [ADDR_W-1:0]    consulta_addr,
  output logic [N_CORES-1:0]   saida,
  output logic [N_CORES-1:0]   consulta_cor,
  output logic                 pronto,
  output logic                 ocupado,
  output logic                 fim_toque
);

  localparam int unsigned CW    = $clog2(N_CORES);
  localparam int unsigned MAX_T = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int unsigned TW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  localparam logic [15:0]         LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [CW:0]         NC        = (CW+1)'(N_CORES);
  localparam logic [ADDR_W:0]     DEPTH_L   = (ADDR_W+1)'(SEQ_DEPTH);
  localparam logic [ADDR_W-1:0]   LAST_IDX  = (ADDR_W)'(SEQ_DEPTH - 1);
  localparam logic [TW-1:0]       SHOW_LAST = (TW)'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0]       GAP_LAST  = (TW)'(GAP_CYCLES - 1);
  localparam logic [N_CORES-1:0]  ONE       = {{(N_CORES-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {StIdle, StFill, StReady, StShow, StGap} state_e;

  state_e              state_q, state_d;
  logic [15:0]         lfsr_q;
  logic                valid_q, valid_d;
  logic                bank_q, bank_d;
  logic [ADDR_W-1:0]   step_q, step_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic [N_CORES-1:0]  consulta_q;
  logic                mem_we;
  logic                fim;
  logic [CW:0]         colour_ext;
  logic [CW-1:0]       colour;
  logic [ADDR_W:0]     len_clamp;
  logic                last_step;

  // Two banks: FILL writes the inactive one so lookups keep seeing the previous sequence.
  logic [CW-1:0]       mem [2*SEQ_DEPTH];

  function automatic logic [N_CORES-1:0] onehot(input logic [CW-1:0] c);
    return ONE << c;
  endfunction

  always_comb begin
    colour_ext = {1'b0, lfsr_q[CW-1:0]};
    if (colour_ext >= NC) colour_ext = colour_ext - NC;
    colour = colour_ext[CW-1:0];
  end

  always_comb begin
    if (nivel == '0)          len_clamp = (ADDR_W+1)'(1);
    else if (nivel > DEPTH_L) len_clamp = DEPTH_L;
    else                      len_clamp = nivel;
  end

  assign last_step = ({1'b0, step_q} == (len_q - (ADDR_W+1)'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      lfsr_q     <= LFSR_INIT;
      valid_q    <= 1'b0;
      bank_q     <= 1'b0;
      step_q     <= '0;
      len_q      <= '0;
      tmr_q      <= '0;
      consulta_q <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      valid_q    <= valid_d;
      bank_q     <= bank_d;
      step_q     <= step_d;
      len_q      <= len_d;
      tmr_q      <= tmr_d;
      consulta_q <= valid_q ? onehot(mem[{bank_q, consulta_addr}]) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[{~bank_q, step_q}] <= colour;
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    bank_d  = bank_q;
    step_d  = step_q;
    len_d   = len_q;
    tmr_d   = tmr_q;
    mem_we  = 1'b0;
    fim     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (novo_jogo) begin
          state_d = StFill;
          step_d  = '0;
        end
      end
      StFill: begin
        mem_we = 1'b1;
        step_d = step_q + (ADDR_W)'(1);
        if (step_q == LAST_IDX) begin
          valid_d = 1'b1;
          bank_d  = ~bank_q;
          state_d = StReady;
        end
      end
      StReady: begin
        if (novo_jogo) begin
          state_d = StFill;
          step_d  = '0;
        end else if (tocar) begin
          len_d   = len_clamp;
          step_d  = '0;
          tmr_d   = '0;
          state_d = StShow;
        end
      end
      StShow: begin
        if (novo_jogo) begin
          state_d = StFill;
          step_d  = '0;
        end else if (tmr_q == SHOW_LAST) begin
          tmr_d   = '0;
          state_d = StGap;
        end else begin
          tmr_d = tmr_q + (TW)'(1);
        end
      end
      StGap: begin
        if (novo_jogo) begin
          state_d = StFill;
          step_d  = '0;
        end else if (tmr_q == GAP_LAST) begin
          tmr_d = '0;
          if (last_step) begin
            fim     = 1'b1;
            state_d = StReady;
          end else begin
            step_d  = step_q + (ADDR_W)'(1);
            state_d = StShow;
          end
        end else begin
          tmr_d = tmr_q + (TW)'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign saida        = (state_q == StShow) ? onehot(mem[{bank_q, step_q}]) : '0;
  assign pronto       = (state_q == StReady);
  assign ocupado      = (state_q == StFill) || (state_q == StShow) || (state_q == StGap);
  assign fim_toque    = fim;
  assign consulta_cor = consulta_q;

endmodule

// File: tb/tb_gen_seq_genius.sv
// Bench for gen_seq_genius: timeline model of fill/playback/lookup checked every cycle,
// plus directed timing and literal colour checks on a 4-colour and a 3-colour build.
module tb_gen_seq_genius;

  localparam int D = 16;
  localparam int S = 4;
  localparam int G = 2;
  localparam int P = S + G;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       novo_jogo = 1'b0;
  logic       tocar = 1'b0;
  logic [4:0] nivel = '0;
  logic [3:0] consulta_addr = '0;
  logic [3:0] saida, consulta_cor;
  logic       pronto, ocupado, fim_toque;
  logic [2:0] saida3, consulta3;
  logic       pronto3, ocupado3, fim3;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  gen_seq_genius #(.N_CORES(4), .SEQ_DEPTH(D), .SEED(16'h0001),
                   .SHOW_CYCLES(S), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n), .novo_jogo(novo_jogo), .tocar(tocar), .nivel(nivel),
    .consulta_addr(consulta_addr), .saida(saida), .consulta_cor(consulta_cor),
    .pronto(pronto), .ocupado(ocupado), .fim_toque(fim_toque));

  gen_seq_genius #(.N_CORES(3), .SEQ_DEPTH(D), .SEED(16'h0001),
                   .SHOW_CYCLES(S), .GAP_CYCLES(G)) dut3 (
    .clk(clk), .rst_n(rst_n), .novo_jogo(novo_jogo), .tocar(tocar), .nivel(nivel),
    .consulta_addr(consulta_addr), .saida(saida3), .consulta_cor(consulta3),
    .pronto(pronto3), .ocupado(ocupado3), .fim_toque(fim3));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // mode: 0 idle, 1 filling, 2 ready, 3 playing (e = cycles since first shown colour)
  int          mode = 0;
  int          fill_left = 0;
  int          e = 0;
  int          plen = 0;
  logic [15:0] mlfsr = 16'h0001;
  logic [15:0] ml;
  logic        m_valid = 1'b0;
  int          seq4[D];
  int          seq3[D];
  int          pend4[D];
  int          pend3[D];
  logic [3:0]  exp_con4 = '0;
  logic [2:0]  exp_con3 = '0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic int colour(input logic [15:0] l, input int n);
    int cw, c;
    cw = $clog2(n);
    c  = int'(l) % (1 << cw);
    if (c >= n) c = c - n;
    return c;
  endfunction

  task automatic start_fill(input logic [15:0] l);
    logic [15:0] x;
    x = l;
    for (int k = 0; k < D; k++) begin
      x = lfsr_next(x);
      pend4[k] = colour(x, 4);
      pend3[k] = colour(x, 3);
    end
    fill_left = D;
    mode = 1;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mode = 0; m_valid = 1'b0; mlfsr = 16'h0001; exp_con4 = '0; exp_con3 = '0; e = 0;
    end else begin
      ml = mlfsr;
      mlfsr = lfsr_next(ml);
      exp_con4 = m_valid ? 4'(1 << seq4[consulta_addr]) : 4'd0;
      exp_con3 = m_valid ? 3'(1 << seq3[consulta_addr]) : 3'd0;
      case (mode)
        0: if (novo_jogo) start_fill(ml);
        1: begin
          fill_left--;
          if (fill_left == 0) begin
            for (int k = 0; k < D; k++) begin
              seq4[k] = pend4[k];
              seq3[k] = pend3[k];
            end
            m_valid = 1'b1;
            mode = 2;
          end
        end
        2: begin
          if (novo_jogo) start_fill(ml);
          else if (tocar) begin
            plen = (nivel == 0) ? 1 : ((int'(nivel) > D) ? D : int'(nivel));
            e = 0;
            mode = 3;
          end
        end
        default: begin
          if (novo_jogo) start_fill(ml);
          else begin
            e++;
            if (e == plen * P) mode = 2;
          end
        end
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      logic [3:0] es4;
      logic [2:0] es3;
      logic       ef, showing;
      int         step, ph;
      es4 = '0; es3 = '0; ef = 1'b0; showing = 1'b0;
      if (mode == 3) begin
        step = e / P;
        ph   = e % P;
        if (ph < S) begin
          es4 = 4'(1 << seq4[step]);
          es3 = 3'(1 << seq3[step]);
          showing = 1'b1;
        end
        ef = (e == plen * P - 1) && !novo_jogo;
      end
      check("saida", 32'(saida), 32'(es4));
      check("pronto", 32'(pronto), 32'(mode == 2));
      check("ocupado", 32'(ocupado), 32'(mode == 1 || mode == 3));
      check("fim_toque", 32'(fim_toque), 32'(ef));
      check("consulta_cor", 32'(consulta_cor), 32'(exp_con4));
      check("saida3", 32'(saida3), 32'(es3));
      check("consulta3", 32'(consulta3), 32'(exp_con3));
      check("pronto3", 32'(pronto3), 32'(mode == 2));
      check("ocupado3", 32'(ocupado3), 32'(mode == 1 || mode == 3));
      check("fim3", 32'(fim3), 32'(ef));
      if (showing)
        check("saida3_legal", 32'(saida3 == 3'b001 || saida3 == 3'b010 || saida3 == 3'b100), 1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the first FILL cycle (or later); exp counts cycles from that point to pronto.
  task automatic wait_ready(input string nm, input int exp);
    int n, fims;
    n = 1; fims = 0;
    while (!pronto && n < 100) begin
      tick();
      n++;
      if (fim_toque) fims++;
    end
    check(nm, 32'(n), 32'(exp));
    check({nm, "_nofim"}, 32'(fims), 0);
  endtask

  task automatic play(input int niv, input int exp, input string nm);
    int n;
    nivel = 5'(niv);
    tocar = 1'b1;
    tick();
    tocar = 1'b0;
    n = 1;
    while (!fim_toque && n < 400) begin
      tick();
      n++;
    end
    check(nm, 32'(n), 32'(exp));
    tick();
    check({nm, "_pronto"}, 32'(pronto), 1);
  endtask

  task automatic read_all();
    for (int a = 0; a < D; a++) begin
      consulta_addr = 4'(a);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // 1: fill straight after reset release
    repeat (3) tick();
    novo_jogo = 1'b1;
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick();
    novo_jogo = 1'b0;
    wait_ready("fill_len", 17);
    read_all();
    consulta_addr = 4'd0;  tick(); check("entry0", 32'(consulta_cor), 32'h1);
    consulta_addr = 4'd9;  tick(); check("entry9", 32'(consulta_cor), 32'h4);
    consulta_addr = 4'd10; tick(); check("entry10", 32'(consulta_cor), 32'h2);
    check("entry10_n3", 32'(consulta3), 32'h2);

    // 2, 3: playback lengths
    play(3, 18, "play_niv3");
    play(0, 6, "play_niv0");
    play(20, 96, "play_niv20");

    // 4: abort during the second SHOW step
    nivel = 5'd5;
    tocar = 1'b1;
    tick();
    tocar = 1'b0;
    repeat (6) tick();
    check("show_step1", 32'(saida), 32'h1);
    novo_jogo = 1'b1;
    tick();
    novo_jogo = 1'b0;
    check("abort_saida", 32'(saida), 0);
    check("abort_ocupado", 32'(ocupado), 1);
    wait_ready("abort_fill", 17);
    read_all();

    // 6: asynchronous reset in the middle of GAP
    nivel = 5'd4;
    tocar = 1'b1;
    tick();
    tocar = 1'b0;
    repeat (4) tick();
    check("gap_saida", 32'(saida), 0);
    check("gap_ocupado", 32'(ocupado), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_saida", 32'(saida), 0);
    check("rst_pronto", 32'(pronto), 0);
    check("rst_ocupado", 32'(ocupado), 0);
    check("rst_fim", 32'(fim_toque), 0);
    check("rst_consulta", 32'(consulta_cor), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick();

    // 5: tocar ignored in IDLE and FILL; novo_jogo wins over tocar in READY
    tocar = 1'b1;
    tick();
    tocar = 1'b0;
    check("idle_tocar_saida", 32'(saida), 0);
    check("idle_tocar_ocupado", 32'(ocupado), 0);
    novo_jogo = 1'b1;
    tick();
    novo_jogo = 1'b0;
    repeat (3) tick();
    nivel = 5'd2;
    tocar = 1'b1;
    tick();
    tocar = 1'b0;
    check("fill_tocar_saida", 32'(saida), 0);
    check("fill_tocar_ocupado", 32'(ocupado), 1);
    wait_ready("fill_tocar_len", 13);
    tocar = 1'b1;
    novo_jogo = 1'b1;
    tick();
    tocar = 1'b0;
    novo_jogo = 1'b0;
    check("both_saida", 32'(saida), 0);
    check("both_pronto", 32'(pronto), 0);
    check("both_ocupado", 32'(ocupado), 1);
    wait_ready("both_fill", 17);
    play(2, 12, "play_niv2");
    read_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
